// File: rtl/uart_word_io.sv
// uart_word_io: assembles UART bytes into words through a small RX FIFO,
// and serialises core words back into bytes for the UART sender.
module uart_word_io #(
  parameter int WORD_BYTES = 4,
  parameter bit BIG_ENDIAN = 1'b1,
  parameter int RX_DEPTH   = 4,
  localparam int W  = 8 * WORD_BYTES,
  localparam int CW = $clog2(RX_DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic [7:0]    in_byte,
  input  logic          in_valid,
  output logic [7:0]    out_byte,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  rx_word,
  output logic          rx_word_valid,
  input  logic          rx_word_ready,
  input  logic [W-1:0]  tx_word,
  input  logic          tx_word_valid,
  output logic          tx_word_ready,
  input  logic          rx_abort,
  output logic [CW-1:0] rx_count,
  output logic          rx_overflow,
  input  logic          ovf_clr
);

  localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int PW = $clog2(RX_DEPTH);
  localparam logic [IW-1:0] LAST = IW'(WORD_BYTES - 1);
  localparam logic [CW-1:0] FULL = CW'(RX_DEPTH);

  // byte index on the wire -> byte lane within the word
  function automatic logic [IW-1:0] slot(input logic [IW-1:0] i);
    return BIG_ENDIAN ? LAST - i : i;
  endfunction

  function automatic logic [7:0] pick(
    input logic [W-1:0]  w,
    input logic [IW-1:0] i
  );
    logic [W-1:0] sh;
    sh = w >> {slot(i), 3'b000};
    return sh[7:0];
  endfunction

  logic [IW-1:0] ri_q, ri_n;
  logic [W-1:0]  asm_q, asm_n, word;
  logic          push;

  always_comb begin
    ri_n  = ri_q;
    asm_n = asm_q;
    word  = asm_q;
    push  = 1'b0;
    if (rx_abort) begin
      ri_n  = '0;
      asm_n = '0;
    end else if (in_valid) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (slot(ri_q) == IW'(b)) word[b*8 +: 8] = in_byte;
      end
      if (ri_q == LAST) begin
        push  = 1'b1;
        ri_n  = '0;
        asm_n = '0;
      end else begin
        ri_n  = ri_q + 1'b1;
        asm_n = word;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ri_q  <= '0;
      asm_q <= '0;
    end else begin
      ri_q  <= ri_n;
      asm_q <= asm_n;
    end
  end

  logic [W-1:0]  mem [RX_DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          valid_q, ovf_q;
  logic          full, pop, wr;

  assign full = (cnt_q == FULL);
  assign pop  = valid_q && rx_word_ready;
  // a full FIFO still takes a word when the head leaves the same cycle
  assign wr   = push && (!full || pop);

  always_comb begin
    unique case ({wr, pop})
      2'b10:   cnt_n = cnt_q + 1'b1;
      2'b01:   cnt_n = cnt_q - 1'b1;
      default: cnt_n = cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (wr) mem[wp_q] <= word;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (wr)  wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
      cnt_q   <= cnt_n;
      valid_q <= (cnt_n != '0);
      if (push && full && !pop) ovf_q <= 1'b1;
      else if (ovf_clr)         ovf_q <= 1'b0;
    end
  end

  assign rx_word       = valid_q ? mem[rp_q] : '0;
  assign rx_word_valid = valid_q;
  assign rx_count      = cnt_q;
  assign rx_overflow   = ovf_q;

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state_q, state_n;
  logic [W-1:0]  tx_q, tx_n;
  logic [IW-1:0] ti_q, ti_n;
  logic          ov_q, ov_n;
  logic [7:0]    ob_q, ob_n;

  always_comb begin
    state_n = state_q;
    tx_n    = tx_q;
    ti_n    = ti_q;
    ov_n    = ov_q;
    ob_n    = ob_q;
    unique case (state_q)
      IDLE: begin
        if (tx_word_valid) begin
          state_n = SEND;
          tx_n    = tx_word;
          ti_n    = '0;
          ov_n    = 1'b1;
          ob_n    = pick(tx_word, '0);
        end
      end
      SEND: begin
        if (out_ready) begin
          if (ti_q == LAST) begin
            state_n = IDLE;
            ov_n    = 1'b0;
            ob_n    = '0;
          end else begin
            ti_n = ti_q + 1'b1;
            ob_n = pick(tx_q, ti_q + 1'b1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      tx_q    <= '0;
      ti_q    <= '0;
      ov_q    <= 1'b0;
      ob_q    <= '0;
    end else begin
      state_q <= state_n;
      tx_q    <= tx_n;
      ti_q    <= ti_n;
      ov_q    <= ov_n;
      ob_q    <= ob_n;
    end
  end

  assign tx_word_ready = (state_q == IDLE);
  assign out_valid     = ov_q;
  assign out_byte      = ob_q;

endmodule

// File: tb/tb_uart_word_io.sv
// tb_uart_word_io: directed stimulus with queue scoreboards for RX words,
// TX bytes and a little-endian instance.
module tb_uart_word_io;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic [7:0]  in_byte = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] rx_word;
  logic        rx_word_valid;
  logic        rx_word_ready = 1'b0;
  logic [31:0] tx_word = '0;
  logic        tx_word_valid = 1'b0;
  logic        tx_word_ready;
  logic        rx_abort = 1'b0;
  logic [2:0]  rx_count;
  logic        rx_overflow;
  logic        ovf_clr = 1'b0;

  logic [7:0]  le_in_byte = '0;
  logic        le_in_valid = 1'b0;
  logic [7:0]  le_out_byte;
  logic        le_out_valid;
  logic [31:0] le_rx_word;
  logic        le_rx_word_valid;
  logic        le_rx_word_ready = 1'b0;
  logic        le_tx_word_ready;
  logic [2:0]  le_rx_count;
  logic        le_rx_overflow;

  int checks = 0;
  int errors = 0;
  logic [31:0] rxq[$];
  logic [31:0] leq[$];
  logic [7:0]  txq[$];

  always #5 CLK = ~CLK;

  uart_word_io #(.WORD_BYTES(4), .BIG_ENDIAN(1'b1), .RX_DEPTH(4)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .in_byte(in_byte), .in_valid(in_valid),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .rx_word(rx_word), .rx_word_valid(rx_word_valid),
    .rx_word_ready(rx_word_ready),
    .tx_word(tx_word), .tx_word_valid(tx_word_valid),
    .tx_word_ready(tx_word_ready),
    .rx_abort(rx_abort), .rx_count(rx_count),
    .rx_overflow(rx_overflow), .ovf_clr(ovf_clr)
  );

  uart_word_io #(.WORD_BYTES(4), .BIG_ENDIAN(1'b0), .RX_DEPTH(4)) dut_le (
    .CLK(CLK), .RSTN(RSTN),
    .in_byte(le_in_byte), .in_valid(le_in_valid),
    .out_byte(le_out_byte), .out_valid(le_out_valid), .out_ready(1'b0),
    .rx_word(le_rx_word), .rx_word_valid(le_rx_word_valid),
    .rx_word_ready(le_rx_word_ready),
    .tx_word(32'h0), .tx_word_valid(1'b0),
    .tx_word_ready(le_tx_word_ready),
    .rx_abort(1'b0), .rx_count(le_rx_count),
    .rx_overflow(le_rx_overflow), .ovf_clr(1'b0)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual output-present required no-output", name);
  endtask

  always @(negedge CLK) begin
    if (RSTN) begin
      if (rx_word_valid && rx_word_ready) begin
        if (rxq.size() == 0) miss("rx_unexpected");
        else chk("rx_word", rx_word, rxq.pop_front());
      end
      if (le_rx_word_valid && le_rx_word_ready) begin
        if (leq.size() == 0) miss("le_unexpected");
        else chk("le_rx_word", le_rx_word, leq.pop_front());
      end
      if (out_valid) begin
        chk("tx_ready_low", tx_word_ready, 0);
        if (txq.size() == 0) miss("tx_unexpected");
        else begin
          chk("out_byte", out_byte, txq[0]);
          if (out_ready) void'(txq.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic rx_byte(input logic [7:0] b, input logic pop);
    in_byte       = b;
    in_valid      = 1'b1;
    rx_word_ready = pop;
    tick();
    in_valid      = 1'b0;
    rx_word_ready = 1'b0;
  endtask

  task automatic rx_be(input logic [31:0] w, input bit keep);
    if (keep) rxq.push_back(w);
    rx_byte(w[31:24], 1'b0);
    rx_byte(w[23:16], 1'b0);
    rx_byte(w[15:8], 1'b0);
    rx_byte(w[7:0], 1'b0);
  endtask

  task automatic pop_one();
    rx_word_ready = 1'b1;
    tick();
    rx_word_ready = 1'b0;
  endtask

  task automatic le_byte(input logic [7:0] b);
    le_in_byte  = b;
    le_in_valid = 1'b1;
    tick();
    le_in_valid = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_byte"}, out_byte, 0);
    chk({tag, "_tx_ready"}, tx_word_ready, 1);
    chk({tag, "_rx_valid"}, rx_word_valid, 0);
    chk({tag, "_rx_word"}, rx_word, 0);
    chk({tag, "_rx_count"}, rx_count, 0);
    chk({tag, "_rx_ovf"}, rx_overflow, 0);
  endtask

  initial begin
    #12;
    chk_reset_state("reset");
    RSTN = 1'b1;
    tick();

    rx_be(32'h0000_00EC, 1'b1);
    chk("be_valid", rx_word_valid, 1);
    chk("be_word", rx_word, 32'h0000_00EC);
    chk("be_count", rx_count, 1);
    pop_one();
    chk("be_pop_valid", rx_word_valid, 0);
    chk("be_pop_word", rx_word, 0);

    leq.push_back(32'h0000_00EC);
    leq.push_back(32'h4433_2211);
    le_byte(8'hEC); le_byte(8'h00); le_byte(8'h00); le_byte(8'h00);
    le_byte(8'h11); le_byte(8'h22); le_byte(8'h33); le_byte(8'h44);
    chk("le_count", le_rx_count, 2);
    le_rx_word_ready = 1'b1;
    tick(); tick();
    le_rx_word_ready = 1'b0;
    chk("le_drained", le_rx_word_valid, 0);

    for (int i = 1; i <= 5; i++) rx_be(32'(i), i <= 4);
    chk("ovf_count", rx_count, 4);
    chk("ovf_flag", rx_overflow, 1);
    for (int i = 0; i < 4; i++) pop_one();
    chk("ovf_popped", rx_count, 0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", rx_overflow, 0);
    for (int i = 6; i <= 9; i++) rx_be(32'(i), 1'b1);
    chk("full_count", rx_count, 4);
    rxq.push_back(32'hA);
    rx_byte(8'h00, 1'b0); rx_byte(8'h00, 1'b0); rx_byte(8'h00, 1'b0);
    rx_byte(8'h0A, 1'b1);
    chk("full_pp_count", rx_count, 4);
    chk("full_pp_ovf", rx_overflow, 0);
    for (int i = 0; i < 4; i++) pop_one();
    chk("full_drained", rx_count, 0);

    txq.push_back(8'h00); txq.push_back(8'h00);
    txq.push_back(8'h00); txq.push_back(8'hF0);
    tx_word       = 32'h0000_00F0;
    tx_word_valid = 1'b1;
    tick();
    tx_word_valid = 1'b0;
    tx_word       = 32'hDEAD_BEEF;
    for (int i = 0; i < 40 && txq.size() > 0; i++) begin
      out_ready = (i % 2 == 1);
      tick();
    end
    out_ready = 1'b0;
    chk("tx_done", txq.size(), 0);
    chk("tx_ready_back", tx_word_ready, 1);
    chk("tx_valid_off", out_valid, 0);

    rx_byte(8'h11, 1'b0);
    rx_byte(8'h22, 1'b0);
    rx_abort = 1'b1;
    rx_byte(8'h33, 1'b0);
    rx_abort = 1'b0;
    rx_be(32'h0000_0020, 1'b1);
    chk("abort_count", rx_count, 1);
    chk("abort_word", rx_word, 32'h0000_0020);
    pop_one();

    rx_byte(8'hAA, 1'b0);
    rx_byte(8'hBB, 1'b0);
    txq.push_back(8'h01); txq.push_back(8'h02);
    txq.push_back(8'h03); txq.push_back(8'h04);
    tx_word       = 32'h0102_0304;
    tx_word_valid = 1'b1;
    tick();
    tx_word_valid = 1'b0;
    out_ready     = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    chk("mid_third", out_byte, 8'h03);
    RSTN = 1'b0;
    #1;
    txq.delete();
    chk_reset_state("midrst");
    tick();
    RSTN      = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_quiet", out_valid, 0);
    end
    out_ready = 1'b0;
    rx_be(32'h0000_0055, 1'b1);
    chk("post_rst_count", rx_count, 1);
    chk("post_rst_word", rx_word, 32'h0000_0055);
    pop_one();

    chk("rxq_empty", rxq.size(), 0);
    chk("leq_empty", leq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_word_io.md
# uart_word_io

Word-level I/O bridge between the byte-wide UART receiver/sender and the CPU core's IN/OUT datapath. It assembles received bytes into WORD_BYTES-wide words and buffers them in a small RX FIFO. It serialises CPU output words into bytes for the sender. It replaces the fixed 4-byte, per-state IN/OUT sequencing in the core with a parametrised, buffered block that has an explicit handshake on each side.

## Interface
Parameters:
- WORD_BYTES, 4: bytes per word; ≥1; word width W = 8*WORD_BYTES.
- BIG_ENDIAN, 1: 1 = first byte on the wire is bits [W-1:W-8]; 0 = first byte is bits [7:0].
- RX_DEPTH, 4: RX FIFO depth in words; power of 2, ≥2.

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RSTN  in  1  asynchronous, active-low reset.
- in_byte  in  8  byte from UART receiver.
- in_valid  in  1  one-cycle strobe; in_byte valid.
- out_byte  out  8  byte to UART sender.
- out_valid  out  1  out_byte valid.
- out_ready  in  1  sender accepts out_byte this cycle.
- rx_word  out  W  FIFO head word; 0 when FIFO is empty.
- rx_word_valid  out  1  FIFO not empty.
- rx_word_ready  in  1  pop request from the core.
- tx_word  in  W  word to transmit.
- tx_word_valid  in  1  core offers tx_word.
- tx_word_ready  out  1  serialiser idle; can accept a word.
- rx_abort  in  1  discard the partially assembled RX word.
- rx_count  out  $clog2(RX_DEPTH+1)  words held in the FIFO.
- rx_overflow  out  1  sticky flag; a completed word was dropped.
- ovf_clr  in  1  clear rx_overflow.

## Operation
- RX assembler: a byte index counts 0..WORD_BYTES-1, plus a W-bit shift/assembly register.
  - Each in_valid stores in_byte into the slot given by BIG_ENDIAN and increments the index.
  - On the last byte, the completed word (including that byte) is pushed to the FIFO and the index wraps to 0.
- rx_abort forces the index to 0 and discards partial bytes.
  - If rx_abort and in_valid occur in the same cycle, the byte is discarded as well.
  - rx_abort does not affect FIFO contents.
- FIFO is show-ahead: rx_word presents the head. A pop occurs when rx_word_valid && rx_word_ready. rx_word_ready while empty is ignored.
- Push while full:
  - With a pop in the same cycle: the push is accepted and the count is unchanged.
  - Without a pop: the word is dropped and rx_overflow is set.
- rx_overflow is cleared by ovf_clr. If a set and a clear occur in the same cycle, the set wins.
- TX serialiser has two states, IDLE and SEND.
  - tx_word_ready = (state == IDLE).
  - IDLE → SEND on tx_word_valid: latch tx_word and set byte index to 0.
  - In SEND: out_valid = 1, and out_byte is the indexed byte in BIG_ENDIAN order. Each out_valid && out_ready advances the index.
  - The handshake on the last byte returns to IDLE.
- out_byte holds its value and out_valid stays high while out_ready = 0. Changes to tx_word during SEND are ignored.
- Reset values:
  - out_valid 0, out_byte 0.
  - tx_word_ready 1 (state IDLE).
  - rx_word_valid 0, rx_word 0, rx_count 0, rx_overflow 0.
  - RX index 0, FIFO pointers 0.
- Reset mid-operation: the partial RX word, FIFO contents and any in-flight TX word are discarded, with no further output bytes.

## Timing
- RX latency: final in_valid at cycle t → rx_word_valid = 1 and rx_word updated at t+1. rx_count also updates at t+1.
- Pop at t → the next head (or 0/invalid) is presented at t+1.
- TX: word accepted at t (tx_word_valid && tx_word_ready) → out_valid = 1 with the first byte at t+1.
- Each byte takes a minimum of 1 cycle. Minimum spacing between words is WORD_BYTES+1 cycles, because of one IDLE cycle.
- All outputs are registered, except tx_word_ready (decoded from the state register) and rx_word (FIFO read mux on registered pointers).
- in_valid may arrive on consecutive cycles. Every strobe is consumed; no backpressure is exerted on the receiver.

## Test plan
- Big-endian RX (WORD_BYTES=4, BIG_ENDIAN=1): bytes 00 00 00 EC → one cycle after the last byte, rx_word_valid=1, rx_word=0x000000EC, rx_count=1. Pop → valid=0, rx_word=0.
- Little-endian RX (BIG_ENDIAN=0): bytes EC 00 00 00 → rx_word=0x000000EC. Back-to-back bytes on consecutive cycles → two words captured with no loss.
- Overflow (RX_DEPTH=4): push 5 words 0x1..0x5 with no pops → rx_count=4 and rx_overflow=1. Pops return 1,2,3,4. ovf_clr → 0. A 5th push coinciding with a pop while full → accepted, no overflow.
- TX with stalls: tx_word=0x000000F0 → out_byte sequence 00 00 00 F0, held stable while out_ready is toggled 0/1. tx_word_ready is low for the whole SEND and returns high after the last handshake.
- rx_abort after 2 bytes, then send 00 00 00 20 → rx_word=0x00000020, with no stray word from the aborted bytes.
- Reset mid-operation: assert RSTN=0 during the 3rd TX byte and with 2 RX bytes pending → all outputs return to reset values, with no further out_valid and a zero-word FIFO.
